// File: rtl/rf_pkg.sv
// Core-wide sizing for the RV32 integer register file and the types shared with its neighbours.
package rf_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage : rf_pkg

// File: rtl/rf.sv
// RV32 general-purpose register file: two combinational read ports for the rs1/rs2
// operands and one rising-edge write port for rd writeback. An asynchronous active-low
// reset clears the whole array. With HARDWIRE_X0 set, index 0 behaves as the RISC-V x0:
// it reads as zero and discards writes.
module rf
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH  = XLEN,
    parameter int ADDR_WIDTH  = REG_ADDR_W,
    parameter int DEPTH       = NUM_REGS,
    parameter bit HARDWIRE_X0 = 1'b0
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  writeEnable,
    input  logic [ADDR_WIDTH-1:0] readReg1,
    input  logic [ADDR_WIDTH-1:0] readReg2,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    // Storage keeps this exact name so that benches can reach it hierarchically.
    logic [DATA_WIDTH-1:0] registers   [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] registers_d [0:DEPTH-1];

    logic wr_accept;

    // A write to x0 is dropped when x0 is hardwired, so registers[0] never leaves zero.
    always_comb begin
        wr_accept = writeEnable;
        if (HARDWIRE_X0 && (writeReg == '0)) begin
            wr_accept = 1'b0;
        end
    end

    // Next-state array: all entries hold except the single addressed one on an accepted write.
    always_comb begin
        registers_d = registers;
        if (wr_accept) begin
            registers_d[writeReg] = writeData;
        end
    end

    // Reset clears every entry immediately and overrides any write presented at the same time.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            registers <= '{default: '0};
        end else begin
            registers <= registers_d;
        end
    end

    // Read port 1: no bypass, so a same-index write shows only after the clock edge.
    always_comb begin
        readData1 = registers[readReg1];
        if (HARDWIRE_X0 && (readReg1 == '0)) begin
            readData1 = '0;
        end
    end

    // Read port 2: identical to port 1 so both ports agree when they address the same entry.
    always_comb begin
        readData2 = registers[readReg2];
        if (HARDWIRE_X0 && (readReg2 == '0)) begin
            readData2 = '0;
        end
    end

endmodule : rf

// File: tb/tb_rf.sv
// Bench for the register file: a reference array tracks the architectural state, expected
// values are queued as stimulus is applied and retired against the DUT outputs.
module tb_rf;
    import rf_pkg::*;

    logic     clk;
    logic     areset;
    logic     writeEnable;
    reg_idx_t readReg1;
    reg_idx_t readReg2;
    reg_idx_t writeReg;
    word_t    writeData;
    word_t    readData1;
    word_t    readData2;
    word_t    rd1_x0;
    word_t    rd2_x0;

    word_t    model [0:NUM_REGS-1];
    word_t    exp_q [$];
    int       n_vec;
    int       n_err;

    rf dut (
        .clk         (clk),
        .areset      (areset),
        .writeEnable (writeEnable),
        .readReg1    (readReg1),
        .readReg2    (readReg2),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .readData1   (readData1),
        .readData2   (readData2)
    );

    rf #(.HARDWIRE_X0(1'b1)) dut_x0 (
        .clk         (clk),
        .areset      (areset),
        .writeEnable (writeEnable),
        .readReg1    (readReg1),
        .readReg2    (readReg2),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .readData1   (rd1_x0),
        .readData2   (rd2_x0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_val(input string tag, input word_t obs, input word_t exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    // Retire the oldest queued expectation against an observed value.
    task automatic sb_pop(input string tag, input word_t obs);
        word_t exp;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %08h want <none>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            chk_val(tag, obs, exp);
        end
    endtask

    // Drive both read addresses, queue the model contents, then compare once settled.
    task automatic rd_check(input string tag, input int r1, input int r2);
        readReg1 = reg_idx_t'(r1);
        readReg2 = reg_idx_t'(r2);
        exp_q.push_back(model[r1]);
        exp_q.push_back(model[r2]);
        #1;
        sb_pop($sformatf("%s rd1[%0d]", tag, r1), readData1);
        sb_pop($sformatf("%s rd2[%0d]", tag, r2), readData2);
    endtask

    task automatic model_clear();
        for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        areset      = 1'b0;
        writeEnable = 1'b0;
        readReg1    = '0;
        readReg2    = '0;
        writeReg    = '0;
        writeData   = '0;
        model_clear();

        // Reset pulse, then release between edges with writes disabled.
        repeat (2) @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NUM_REGS - 1; i++) rd_check("reset", i, i + 1);

        // Write every register with a distinct pattern, one per cycle.
        for (int i = 0; i < NUM_REGS; i++) begin
            @(negedge clk);
            writeEnable = 1'b1;
            writeReg    = reg_idx_t'(i);
            writeData   = 32'hA5A5_0000 + word_t'(i);
            model[i]    = writeData;
            exp_q.push_back(model[i]);
            @(posedge clk);
            #1;
            sb_pop($sformatf("wr reg[%0d]", i), dut.registers[i]);
        end
        @(negedge clk);
        writeEnable = 1'b0;

        // Read back through both ports.
        for (int i = 0; i < NUM_REGS - 1; i++) rd_check("readback", i, i + 1);
        rd_check("same-index", 17, 17);

        // Hardwired-x0 instance: index 0 reads zero and kept zero, others written normally.
        readReg1 = '0;
        readReg2 = reg_idx_t'(1);
        exp_q.push_back('0);
        exp_q.push_back(model[1]);
        exp_q.push_back('0);
        #1;
        sb_pop("x0 rd1[0]", rd1_x0);
        sb_pop("x0 rd2[1]", rd2_x0);
        sb_pop("x0 storage[0]", dut_x0.registers[0]);

        // Write-disable hold on register 5 across several edges.
        @(negedge clk);
        writeEnable = 1'b0;
        writeReg    = reg_idx_t'(5);
        writeData   = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rd_check("hold", 5, 4);

        // Read-during-write on register 7: old value before the edge, new value after.
        readReg1    = reg_idx_t'(7);
        readReg2    = reg_idx_t'(6);
        writeReg    = reg_idx_t'(7);
        writeData   = 32'h1234_5678;
        writeEnable = 1'b1;
        exp_q.push_back(model[7]);
        #1;
        sb_pop("rdw before", readData1);
        @(posedge clk);
        model[7] = 32'h1234_5678;
        exp_q.push_back(model[7]);
        exp_q.push_back(model[6]);
        #1;
        sb_pop("rdw after", readData1);
        sb_pop("rdw neighbour", readData2);
        @(negedge clk);
        writeEnable = 1'b0;

        // Mid-operation reset between edges with a write pending.
        @(negedge clk);
        writeEnable = 1'b1;
        writeReg    = reg_idx_t'(3);
        writeData   = 32'hCAFE_F00D;
        #2;
        areset = 1'b0;
        model_clear();
        #1;
        rd_check("mid-reset", 7, 20);
        @(posedge clk);
        exp_q.push_back('0);
        #1;
        sb_pop("reset blocks write", dut.registers[3]);
        @(negedge clk);
        writeEnable = 1'b0;
        areset      = 1'b1;
        for (int i = 0; i < NUM_REGS - 1; i += 3) rd_check("post-reset", i, i + 1);

        // First write after release lands on the next rising edge.
        @(negedge clk);
        writeEnable = 1'b1;
        writeReg    = reg_idx_t'(9);
        writeData   = 32'h0BAD_F00D;
        model[9]    = writeData;
        @(posedge clk);
        #1;
        writeEnable = 1'b0;
        rd_check("post-release write", 9, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rf
